// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per clock out on w, MSB first.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module bit_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             w,
    output logic             w_valid,
    output logic             last,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
`ifdef BIT_SERIALIZER_PARITY_EN
        ,
        PARITY = 2'd2
`endif
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sr, sr_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             accept;
    logic             last_bit;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic             par, par_nxt;
`endif

    // Handshake: a word transfers on a rising edge where in_valid && in_ready.
    // in_ready depends on registered state only; in_data is ignored unless a transfer occurs.
    assign accept    = in_valid && in_ready;
    assign last_bit  = (cnt == CNT_LAST);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
`ifdef BIT_SERIALIZER_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            sr    <= sr_nxt;
            cnt   <= cnt_nxt;
`ifdef BIT_SERIALIZER_PARITY_EN
            par   <= par_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        cnt_nxt   = cnt;
`ifdef BIT_SERIALIZER_PARITY_EN
        par_nxt   = par;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                    sr_nxt    = in_data;
                    cnt_nxt   = '0;
`ifdef BIT_SERIALIZER_PARITY_EN
                    par_nxt   = 1'b0;
`endif
                end
            end
            SHIFT: begin
                sr_nxt  = sr << 1;
                cnt_nxt = cnt + CW'(1);
`ifdef BIT_SERIALIZER_PARITY_EN
                par_nxt = par ^ sr[WIDTH-1];
                if (last_bit) begin
                    state_nxt = PARITY;
                end
`else
                if (last_bit) begin
                    // A reload here keeps w_valid continuous across words.
                    if (accept) begin
                        state_nxt = SHIFT;
                        sr_nxt    = in_data;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
`endif
            end
`ifdef BIT_SERIALIZER_PARITY_EN
            PARITY: begin
                if (accept) begin
                    state_nxt = SHIFT;
                    sr_nxt    = in_data;
                    cnt_nxt   = '0;
                    par_nxt   = 1'b0;
                end else begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        w        = 1'b0;
        w_valid  = 1'b0;
        last     = 1'b0;
        busy     = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            SHIFT: begin
                w       = sr[WIDTH-1];
                w_valid = 1'b1;
`ifndef BIT_SERIALIZER_PARITY_EN
                last     = last_bit;
                in_ready = last_bit;
`endif
            end
`ifdef BIT_SERIALIZER_PARITY_EN
            PARITY: begin
                w        = par;
                w_valid  = 1'b1;
                last     = 1'b1;
                in_ready = 1'b1;
            end
`endif
            default: begin
                busy = 1'b1;
            end
        endcase
    end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the sequence-detector stage. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `w`, MSB first, with a qualifying strobe. `w` connects directly to the detector's serial input. The block supports back-to-back words with no idle gap and can optionally append an even-parity bit to each word.

## Interface
- `WIDTH`, default 8: data word width in bits; legal range 2..32.
- `clk`  input  1: clock; all state updates on the rising edge.
- `reset`  input  1: asynchronous, active-low reset.
- `in_data`  input  WIDTH: parallel word; sampled only on an accepting edge.
- `in_valid`  input  1: upstream has a word available.
- `in_ready`  output  1: block accepts a word on this edge if `in_valid` is high.
- `w`  output  1: serial bit to the detector; 0 whenever `w_valid` is low.
- `w_valid`  output  1: `w` carries a data or parity bit this cycle.
- `last`  output  1: the final bit of the current word (data bit 0, or the parity bit) is on `w`.
- `busy`  output  1: high in any state other than IDLE.

## Operation
- State register values: IDLE, SHIFT, and PARITY. PARITY is present only under the macro.
- Datapath: a WIDTH-bit shift register `sr`, a $clog2(WIDTH)-bit counter `cnt`, and a parity accumulator `par`.
- Accept condition: `in_valid && in_ready` at a rising edge. On accept: `sr <= in_data`, `cnt <= 0`, `par <= 0`, next state is SHIFT.
- IDLE:
  - `in_ready=1`, `w=0`, `w_valid=0`, `last=0`, `busy=0`.
  - Stays in IDLE until an accept.
- SHIFT:
  - `w = sr[WIDTH-1]`, `w_valid=1`.
  - Each edge: `sr <= sr << 1`, `cnt <= cnt+1`, `par <= par ^ w`.
  - `last = (cnt==WIDTH-1)`, and only when parity is disabled.
- Leaving SHIFT when `cnt==WIDTH-1`:
  - Parity enabled: go to PARITY.
  - Parity disabled: on an accept in the same cycle, reload and stay in SHIFT; otherwise go to IDLE.
- `in_ready` in SHIFT is high only when `cnt==WIDTH-1` and parity is disabled.
- PARITY:
  - `w = par`, `w_valid=1`, `last=1`, `in_ready=1`.
  - Next state is SHIFT on an accept, otherwise IDLE.
- `in_data` changes while not accepting are ignored. `in_valid` dropping mid-word has no effect on the word in flight.
- Unreachable state encodings return to IDLE on the next edge.

## Timing
- Reset, asserted asynchronously at any time:
  - Forces state IDLE, `sr=0`, `cnt=0`, `par=0`.
  - Outputs go immediately to `in_ready=1`, `w=0`, `w_valid=0`, `last=0`, `busy=0`.
  - A word in flight is discarded. No partial word is resumed after reset release.
- Latency: a word accepted at edge k puts its MSB on `w` during cycle k+1. Bit i (MSB=0) appears during cycle k+1+i.
- Word occupancy on `w`: WIDTH cycles, or WIDTH+1 with parity.
- Throughput: one bit per clock. Back-to-back words produce continuous `w_valid` with no bubble.
- All outputs are functions of registered state only (Moore). There is no combinational path from `in_valid` or `in_data` to any output.

## Configuration
- Macro `BIT_SERIALIZER_PARITY_EN`.
- Defined:
  - The PARITY state is compiled in.
  - Each word is followed by one even-parity bit, equal to the XOR of all WIDTH data bits.
  - `last` marks the parity bit.
- Undefined:
  - There is no PARITY state and no parity logic.
  - `last` marks data bit 0.
  - `in_ready` rises during the final data bit.

## Test plan
- Reset: hold `reset=0` for 3 cycles with `in_valid=1`, `in_data=8'hFF` -> `in_ready=1`, `w=0`, `w_valid=0`, `busy=0` throughout; no word is accepted.
- Single word, macro off, WIDTH=8: accept 8'hB6 -> `w` = 1,0,1,1,0,1,1,0 on 8 consecutive cycles starting one cycle after accept; `last` only on the 8th bit; IDLE afterwards.
- Parity, macro on: accept 8'hB6 (five ones) -> same 8 bits, then a 9th bit `w=1` with `last=1`. Accept 8'h03 -> parity bit 0.
- Back-to-back, macro off: hold `in_valid=1` with 8'hB6 then 8'h0F -> 16 contiguous `w_valid` cycles with bits 10110110 00001111; `in_ready` high only on cycle 8 of each word.
- Reset mid-word: accept 8'hB6, assert reset after the 3rd bit -> outputs go to reset values immediately without waiting for a clock edge; after release, accepting 8'h0F emits 00001111 cleanly.
- Downstream integration: feed 8'hB6 into the detector -> detector `z` rises at the expected cycles for the 110/101 patterns; `w=0` while idle produces no false detections.
